// File: rtl/skid_reg_slice.sv
// Two-entry (main + skid) valid/ready register slice: in_ready and all out_*
// come straight from flops, and completed output handshakes are counted.
`timescale 1ns/1ps
module skid_reg_slice #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] beat_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] skid_reg;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // out_data is the main entry itself; skid only fills when main is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= EMPTY;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      out_data   <= '0;
      skid_reg   <= '0;
      beat_count <= '0;
    end else begin
      if (out_fire)
        beat_count <= beat_count + CNT_W'(1);

      case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            state_reg <= ONE;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
            out_data  <= in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            out_data <= in_data;
          end else if (in_fire) begin
            state_reg <= FULL;
            skid_reg  <= in_data;
            in_ready  <= 1'b0;
          end else if (out_fire) begin
            state_reg <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            state_reg <= ONE;
            out_data  <= skid_reg;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_reg <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skid_reg_slice.sv
// Directed table plus scoreboarded random-bubble run for skid_reg_slice,
// with a narrow-counter instance sharing the stimulus for the wrap check.
`timescale 1ns/1ps
module tb_skid_reg_slice;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [7:0]  out_data;
  logic [15:0] beat_count;
  logic        in_ready4, out_valid4;
  logic [7:0]  out_data4;
  logic [3:0]  beat_count4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  skid_reg_slice #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .beat_count(beat_count)
  );

  skid_reg_slice #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .beat_count(beat_count4)
  );

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic        ordy;
    logic        ov;
    logic        ir;
    logic [7:0]  od;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic ordy,
                              input logic ov, input logic ir, input logic [7:0] od,
                              input logic [15:0] cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.ov = ov; v.ir = ir; v.od = od; v.cnt = cnt;
    return v;
  endfunction

  // Drive inputs, let one rising edge happen, land 1 ns after it.
  task automatic apply(input logic iv, input logic [7:0] d, input logic ordy);
    in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk); #1;
  endtask

  // Mid-cycle reset pulse that spans no clock edge; outputs checked while held.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_ov"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ir"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_od"}, {24'd0, out_data}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, beat_count}, 32'd0);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [15:0] mcnt;
    int delivered;
    int cyc;
    logic iv, ordy, ifire, ofire;
    logic [7:0] d;

    // Reset asserted between edges with random inputs, checked asynchronously.
    in_valid = 1'($urandom); in_data = 8'($urandom); out_ready = 1'($urandom);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_async_ir", {31'd0, in_ready}, 32'd1);
    chk("rst_async_od", {24'd0, out_data}, 32'd0);
    chk("rst_async_cnt", {16'd0, beat_count}, 32'd0);
    chk("rst_async_cnt4", {28'd0, beat_count4}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom); out_ready = 1'b1;
      @(posedge clk); #1;
      chk("rst_held_ov", {31'd0, out_valid}, 32'd0);
      chk("rst_held_cnt", {16'd0, beat_count}, 32'd0);
    end
    #2 rst = 1'b0;

    // Streaming: 16 beats back to back, then drain.
    for (int i = 0; i < 16; i++)
      vt.push_back(mk(1'b1, 8'(i + 1), 1'b1, 1'b1, 1'b1, 8'(i + 1), 16'(i)));
    vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h10, 16'd16));
    // Backpressure into FULL, ignored data while full, then drain in order.
    vt.push_back(mk(1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA1, 16'd16));
    vt.push_back(mk(1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'hA1, 16'd16));
    vt.push_back(mk(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0, 8'hA1, 16'd16));
    vt.push_back(mk(1'b0, 8'hCC, 1'b1, 1'b1, 1'b1, 8'hA2, 16'd17));
    vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA2, 16'd18));
    // ONE: hold, simultaneous in/out, drain; EMPTY ignores data without valid.
    vt.push_back(mk(1'b1, 8'hD1, 1'b0, 1'b1, 1'b1, 8'hD1, 16'd18));
    vt.push_back(mk(1'b0, 8'hE0, 1'b0, 1'b1, 1'b1, 8'hD1, 16'd18));
    vt.push_back(mk(1'b1, 8'hD2, 1'b1, 1'b1, 1'b1, 8'hD2, 16'd19));
    vt.push_back(mk(1'b0, 8'hE1, 1'b1, 1'b0, 1'b1, 8'hD2, 16'd20));
    vt.push_back(mk(1'b0, 8'hEE, 1'b1, 1'b0, 1'b1, 8'hD2, 16'd20));

    foreach (vt[i]) begin
      apply(vt[i].iv, vt[i].d, vt[i].ordy);
      chk($sformatf("vec%0d_ov", i), {31'd0, out_valid}, {31'd0, vt[i].ov});
      chk($sformatf("vec%0d_ir", i), {31'd0, in_ready}, {31'd0, vt[i].ir});
      chk($sformatf("vec%0d_od", i), {24'd0, out_data}, {24'd0, vt[i].od});
      chk($sformatf("vec%0d_cnt", i), {16'd0, beat_count}, {16'd0, vt[i].cnt});
    end

    // Random bubbles against an occupancy/FIFO model.
    mcnt = 16'd20;
    delivered = 0;
    cyc = 0;
    while (delivered < 1000 && cyc < 20000) begin
      iv = 1'($urandom); ordy = 1'($urandom); d = 8'($urandom);
      chk("rnd_ov", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
      chk("rnd_ir", {31'd0, in_ready}, {31'd0, (q.size() < 2)});
      if (q.size() > 0)
        chk("rnd_od", {24'd0, out_data}, {24'd0, q[0]});
      chk("rnd_cnt", {16'd0, beat_count}, {16'd0, mcnt});
      ifire = iv && (q.size() < 2);
      ofire = ordy && (q.size() > 0);
      if (ofire) begin
        void'(q.pop_front());
        delivered++;
        mcnt = mcnt + 16'd1;
      end
      if (ifire)
        q.push_back(d);
      apply(iv, d, ordy);
      cyc++;
    end
    chk("rnd_delivered", delivered, 1000);
    while (q.size() > 0) begin
      chk("drain_od", {24'd0, out_data}, {24'd0, q[0]});
      void'(q.pop_front());
      mcnt = mcnt + 16'd1;
      apply(1'b0, 8'h00, 1'b1);
    end
    chk("drain_ov", {31'd0, out_valid}, 32'd0);
    chk("drain_cnt", {16'd0, beat_count}, {16'd0, mcnt});

    // Counter wrap: 17 handshakes on the 4-bit instance.
    pulse_reset("wrap_rst");
    for (int i = 0; i < 17; i++)
      apply(1'b1, 8'(8'h30 + i), 1'b1);
    apply(1'b0, 8'h00, 1'b1);
    chk("wrap_cnt4", {28'd0, beat_count4}, 32'd1);
    chk("wrap_cnt16", {16'd0, beat_count}, 32'd17);
    chk("wrap_ov", {31'd0, out_valid}, 32'd0);

    // Reset while FULL discards both held beats.
    apply(1'b1, 8'h55, 1'b0);
    apply(1'b1, 8'h66, 1'b0);
    chk("full_ov", {31'd0, out_valid}, 32'd1);
    chk("full_ir", {31'd0, in_ready}, 32'd0);
    chk("full_od", {24'd0, out_data}, 32'h55);
    pulse_reset("midop_rst");
    apply(1'b0, 8'h00, 1'b1);
    chk("post_rst_ov", {31'd0, out_valid}, 32'd0);
    apply(1'b1, 8'h77, 1'b0);
    chk("first_beat_ov", {31'd0, out_valid}, 32'd1);
    chk("first_beat_od", {24'd0, out_data}, 32'h77);
    apply(1'b0, 8'h00, 1'b1);
    chk("after_77_ov", {31'd0, out_valid}, 32'd0);
    chk("after_77_od", {24'd0, out_data}, 32'h77);
    chk("after_77_cnt", {16'd0, beat_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
